ct_loader: RTL and testbench



---
 rtl/ct_loader_pkg.sv | 29 ++
 rtl/ct_loader_row_packer.sv | 46 ++++
 rtl/ct_loader.sv | 161 ++++++++++++++++
 tb/tb_ct_loader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ct_loader_pkg.sv
// ct_loader_pkg -- shared definitions for the ROLLO-I ciphertext loader.
//   Default geometry (N coefficients of M bits, D per RAM row), the derived
//   RAM row width and depth, the loader FSM state encoding and two small
//   sizing helpers used by the top level.
package ct_loader_pkg;

    localparam int CT_N     = 47;
    localparam int CT_M     = 79;
    localparam int CT_D     = 5;
    localparam int CT_WIDTH = CT_M * CT_D;
    localparam int CT_DEPTH = (CT_N + CT_D - 1) / CT_D;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD       = 2'd1,
        ST_WRITE_LAST = 2'd2,
        ST_DONE       = 2'd3
    } state_e;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Counter/address width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/ct_loader_row_packer.sv
// ct_row_packer -- D-slot row assembly register for the ciphertext loader.
//   clk     : clock, rising edge
//   srst    : synchronous active-high reset, clears every slot
//   clr     : clear all slots on the next edge (wins over an insert)
//   ins_en  : write din into slot 'slot' on the next edge
//   slot    : slot index, element goes to bits [M*slot +: M]
//   din     : element to insert
//   row_ins : current row image with this cycle's insert already applied,
//             so the caller can write a row in the same cycle its last
//             element arrives
module ct_row_packer #(
    parameter int M  = 79,
    parameter int D  = 5,
    parameter int SW = 3
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             ins_en,
    input  logic [SW-1:0]    slot,
    input  logic [M-1:0]     din,
    output logic [M*D-1:0]   row_ins
);

    generate
        for (genvar gi = 0; gi < D; gi++) begin : g_slot
            logic [M-1:0] slot_q;
            logic [M-1:0] slot_d;

            assign row_ins[M*gi +: M] = (ins_en && (slot == SW'(gi))) ? din : slot_q;

            always_comb begin
                slot_d = clr ? '0 : row_ins[M*gi +: M];
            end

            always_ff @(posedge clk) begin
                if (srst) begin
                    slot_q <= '0;
                end else begin
                    slot_q <= slot_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/ct_loader.sv
// ct_loader -- streams the ROLLO-I ciphertext c (N elements of GF(2^M)) into
// the single-port ciphertext RAM, D elements per row.
//   clk      : clock, rising edge
//   rst_b    : synchronous, ACTIVE-HIGH reset (the name is historical)
//   start    : one-cycle load request, honoured only in IDLE
//   in_valid / in_data / in_ready : coefficient stream, c_0 first
//   mem_addr / mem_we / mem_do    : registered RAM row write port
//   busy     : load in progress (LOAD and WRITE_LAST)
//   done     : one-cycle pulse when the RAM image is complete
//   parity   : running XOR of accepted coefficients, only when the
//              CLOAD_PARITY_EN macro is defined
module ct_loader
    import ct_loader_pkg::*;
#(
    parameter  int N     = CT_N,
    parameter  int M     = CT_M,
    parameter  int D     = CT_D,
    localparam int WIDTH = M * D,
    localparam int DEPTH = ceil_div(N, D),
    localparam int AW    = clog2_min1(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic             in_valid,
    input  logic [M-1:0]     in_data,
    output logic             in_ready,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_do,
    output logic             busy,
    output logic             done
`ifdef CLOAD_PARITY_EN
    ,
    output logic [M-1:0]     parity
`endif
);

    localparam int EW = clog2_min1(N + 1);
    localparam int SW = clog2_min1(D);

    state_e             state_q, state_d;
    logic [EW-1:0]      elem_q, elem_d;
    logic [SW-1:0]      slot_q, slot_d;
    logic [AW-1:0]      row_q, row_d;
    logic               mem_we_q, mem_we_d;
    logic [AW-1:0]      mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]   mem_do_q, mem_do_d;
    logic               pk_clr, pk_ins;
    logic [WIDTH-1:0]   pk_row;
`ifdef CLOAD_PARITY_EN
    logic [M-1:0]       parity_q, parity_d;
`endif

    ct_row_packer #(
        .M  (M),
        .D  (D),
        .SW (SW)
    ) u_packer (
        .clk     (clk),
        .srst    (rst_b),
        .clr     (pk_clr),
        .ins_en  (pk_ins),
        .slot    (slot_q),
        .din     (in_data),
        .row_ins (pk_row)
    );

    always_comb begin
        state_d    = state_q;
        elem_d     = elem_q;
        slot_d     = slot_q;
        row_d      = row_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_do_d   = mem_do_q;
        pk_clr     = 1'b0;
        pk_ins     = 1'b0;
`ifdef CLOAD_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    elem_d  = '0;
                    slot_d  = '0;
                    row_d   = '0;
                    pk_clr  = 1'b1;
`ifdef CLOAD_PARITY_EN
                    parity_d = '0;
`endif
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    pk_ins = 1'b1;
                    elem_d = elem_q + EW'(1);
`ifdef CLOAD_PARITY_EN
                    parity_d = parity_q ^ in_data;
`endif
                    // Row complete (full, or the short final row): write the
                    // row image including this element, then start afresh.
                    if ((slot_q == SW'(D - 1)) || (elem_q == EW'(N - 1))) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = row_q;
                        mem_do_d   = pk_row;
                        pk_clr     = 1'b1;
                        slot_d     = '0;
                        row_d      = row_q + AW'(1);
                    end else begin
                        slot_d = slot_q + SW'(1);
                    end
                    if (elem_q == EW'(N - 1)) begin
                        state_d = ST_WRITE_LAST;
                    end
                end
            end
            ST_WRITE_LAST: state_d = ST_DONE;
            ST_DONE:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q    <= ST_IDLE;
            elem_q     <= '0;
            slot_q     <= '0;
            row_q      <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_do_q   <= '0;
`ifdef CLOAD_PARITY_EN
            parity_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            elem_q     <= elem_d;
            slot_q     <= slot_d;
            row_q      <= row_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_do_q   <= mem_do_d;
`ifdef CLOAD_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign in_ready = (state_q == ST_LOAD);
    assign busy     = (state_q == ST_LOAD) || (state_q == ST_WRITE_LAST);
    assign done     = (state_q == ST_DONE);
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_do   = mem_do_q;
`ifdef CLOAD_PARITY_EN
    assign parity   = parity_q;
`endif

endmodule

// File: tb/tb_ct_loader.sv
// tb_ct_loader -- randomized self-checking bench for ct_loader.
//   Two instances: index 0 with N=47 (short last row), index 1 with N=50
//   (last row full). A reference model fills an expected row image from the
//   coefficient list and predicts write timing from handshake cycles.
module tb_ct_loader;

    localparam int M  = 79;
    localparam int D  = 5;
    localparam int WB = M * D;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            rst_b;
    logic            start_v    [2];
    logic            in_valid_v [2];
    logic [M-1:0]    in_data_v  [2];
    logic            in_ready_v [2];
    logic [AW-1:0]   mem_addr_v [2];
    logic            mem_we_v   [2];
    logic [WB-1:0]   mem_do_v   [2];
    logic            busy_v     [2];
    logic            done_v     [2];
`ifdef CLOAD_PARITY_EN
    logic [M-1:0]    parity_v   [2];
`endif

    always #5 clk = ~clk;

    ct_loader #(.N(47), .M(M), .D(D)) u_dut_a (
        .clk      (clk),
        .rst_b    (rst_b),
        .start    (start_v[0]),
        .in_valid (in_valid_v[0]),
        .in_data  (in_data_v[0]),
        .in_ready (in_ready_v[0]),
        .mem_addr (mem_addr_v[0]),
        .mem_we   (mem_we_v[0]),
        .mem_do   (mem_do_v[0]),
        .busy     (busy_v[0]),
        .done     (done_v[0])
`ifdef CLOAD_PARITY_EN
        ,
        .parity   (parity_v[0])
`endif
    );

    ct_loader #(.N(50), .M(M), .D(D)) u_dut_b (
        .clk      (clk),
        .rst_b    (rst_b),
        .start    (start_v[1]),
        .in_valid (in_valid_v[1]),
        .in_data  (in_data_v[1]),
        .in_ready (in_ready_v[1]),
        .mem_addr (mem_addr_v[1]),
        .mem_we   (mem_we_v[1]),
        .mem_do   (mem_do_v[1]),
        .busy     (busy_v[1]),
        .done     (done_v[1])
`ifdef CLOAD_PARITY_EN
        ,
        .parity   (parity_v[1])
`endif
    );

    int n_checks = 0;
    int n_errs   = 0;

    logic [M-1:0] cdata  [64];
    int           hs_cyc [64];

    task automatic check(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected row r: element r*D+s in slot s, zero past the last coefficient.
    function automatic logic [WB-1:0] exp_row(input int n, input int r);
        logic [WB-1:0] v;
        v = '0;
        for (int s = 0; s < D; s++) begin
            if (r * D + s < n) v[M*s +: M] = cdata[r * D + s];
        end
        return v;
    endfunction

    task automatic check_idle(input int idx, input string tag);
        check($sformatf("%s_in_ready%0d", tag, idx), WB'(in_ready_v[idx]), '0);
        check($sformatf("%s_mem_we%0d", tag, idx), WB'(mem_we_v[idx]), '0);
        check($sformatf("%s_mem_addr%0d", tag, idx), WB'(mem_addr_v[idx]), '0);
        check($sformatf("%s_mem_do%0d", tag, idx), mem_do_v[idx], '0);
        check($sformatf("%s_busy%0d", tag, idx), WB'(busy_v[idx]), '0);
        check($sformatf("%s_done%0d", tag, idx), WB'(done_v[idx]), '0);
`ifdef CLOAD_PARITY_EN
        check($sformatf("%s_parity%0d", tag, idx), WB'(parity_v[idx]), '0);
`endif
    endtask

    // One load on instance idx. rand_data=0 gives c_j=j+1. restart_at pulses
    // start with element restart_at; abort_at resets instead of sending it.
    task automatic run_load(input string name, input int idx, input int rand_data,
                            input int bubble_pct, input int restart_at, input int abort_at);
        int n, depth, j, nw, cyc, last_w, done_cyc, last_el;
        logic [95:0]  t;
        logic [M-1:0] par;
        n = (idx != 0) ? 50 : 47;
        depth = (n + D - 1) / D;
        j = 0; nw = 0; cyc = 0; last_w = -1; done_cyc = -1;
        par = '0;
        for (int k = 0; k < n; k++) begin
            t = {$urandom, $urandom, $urandom};
            cdata[k] = (rand_data != 0) ? t[M-1:0] : M'(k + 1);
        end
        @(negedge clk);
        start_v[idx]    = 1'b1;
        in_valid_v[idx] = 1'b1;       // ignored: loader is still idle
        in_data_v[idx]  = '1;
        while (cyc < 600) begin
            @(negedge clk);
            cyc++;
            start_v[idx]    = 1'b0;
            in_valid_v[idx] = 1'b0;
            if (cyc == 1) check($sformatf("%s_busy_on", name), WB'(busy_v[idx]), WB'(1));
            if (mem_we_v[idx]) begin
                last_el = (nw * D + D - 1 < n) ? nw * D + D - 1 : n - 1;
                check($sformatf("%s_addr_r%0d", name, nw), WB'(mem_addr_v[idx]), WB'(nw));
                check($sformatf("%s_data_r%0d", name, nw), mem_do_v[idx], exp_row(n, nw));
                check($sformatf("%s_wcyc_r%0d", name, nw), WB'(cyc), WB'(hs_cyc[last_el] + 1));
                last_w = cyc;
                nw++;
            end
            if (done_v[idx]) begin
                done_cyc = cyc;
`ifdef CLOAD_PARITY_EN
                check($sformatf("%s_parity_done", name), WB'(parity_v[idx]), WB'(par));
`endif
                break;
            end
            if (in_ready_v[idx] && j < n && ($urandom_range(99) >= bubble_pct)) begin
                if (j == abort_at) begin
                    rst_b = 1'b1;
                    @(negedge clk);
                    rst_b = 1'b0;
                    check_idle(idx, $sformatf("%s_abort", name));
                    return;
                end
                in_valid_v[idx] = 1'b1;
                in_data_v[idx]  = cdata[j];
                hs_cyc[j] = cyc;
                par ^= cdata[j];
                if (j == restart_at) start_v[idx] = 1'b1;
                j++;
            end
        end
        check($sformatf("%s_timeout", name), WB'(done_cyc < 0), '0);
        check($sformatf("%s_wcount", name), WB'(nw), WB'(depth));
        check($sformatf("%s_done_lat", name), WB'(done_cyc), WB'(last_w + 1));
        if (bubble_pct == 0 && restart_at < 0)
            check($sformatf("%s_done_cyc", name), WB'(done_cyc), WB'(n + 2));
        $display("load %s: inst=%0d writes=%0d done_cycle=%0d", name, idx, nw, done_cyc);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("%s_busy_off%0d", name, k), WB'(busy_v[idx]), '0);
            check($sformatf("%s_done_off%0d", name, k), WB'(done_v[idx]), '0);
`ifdef CLOAD_PARITY_EN
            check($sformatf("%s_parity_hold%0d", name, k), WB'(parity_v[idx]), WB'(par));
`endif
        end
    endtask

    initial begin
        rst_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_v[i]    = 1'b0;
            in_valid_v[i] = 1'b0;
            in_data_v[i]  = '0;
        end
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        check_idle(0, "reset");
        check_idle(1, "reset");

        run_load("seq_nostall",  0, 0, 0,  -1, -1);
        run_load("rand_bubble",  0, 1, 40, -1, -1);
        run_load("restart_ign",  0, 1, 20, 20, -1);
        run_load("abort",        0, 1, 0,  -1, 23);
        run_load("after_abort",  0, 1, 30, -1, -1);
        run_load("n50_nostall",  1, 0, 0,  -1, -1);
        run_load("n50_bubble",   1, 1, 40, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
